// File: rtl/rr_arbiter4.sv
// rr_arbiter4: four-requester round-robin arbiter with a per-owner hold limit.
//
// A winner is chosen by searching req starting at the priority pointer and
// wrapping modulo 4. The grant is registered and held until the owner
// releases, drops its request, or reaches MAX_HOLD consecutive cycles. Every
// ownership change passes through one dead cycle (GAP) for bus turnaround.
//
// Parameters:
//   MAX_HOLD       maximum consecutive grant cycles per owner, 0 = unlimited (0..255)
// Ports:
//   CLK            rising-edge clock
//   Reset_L        synchronous active-low reset
//   req[3:0]       level-sensitive request, bit i = master i
//   release_grant  current owner is finished (the plain name "release" is a
//                  SystemVerilog keyword); ignored outside GRANT
//   grant[3:0]     registered one-hot grant, or 4'b0000
//   grant_idx[1:0] index of the current or most recent owner
//   busy           high exactly while a grant is active
//   timeout        one-cycle pulse when a grant is revoked by the hold limit

module rr_arbiter4 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       CLK,
    input  logic       Reset_L,
    input  logic [3:0] req,
    input  logic       release_grant,
    output logic [3:0] grant,
    output logic [1:0] grant_idx,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StGrant = 2'd1,
        StGap   = 2'd2
    } state_e;

    // With MAX_HOLD = 0 HoldLast wraps to 8'hFF but is never used.
    localparam bit       HoldEn   = (MAX_HOLD != 0);
    localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);

    state_e     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] idx_q, idx_d;
    logic [7:0] hold_q, hold_d;
    logic       timeout_q, timeout_d;

    logic       win_found;
    logic [1:0] win_idx;
    logic       limit_hit;
    logic       exit_grant;

    // Rotating search: ptr, ptr+1, ptr+2, ptr+3 (2-bit add wraps naturally).
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        for (int i = 0; i < 4; i++) begin
            if (!win_found && req[ptr_q + 2'(i)]) begin
                win_found = 1'b1;
                win_idx   = ptr_q + 2'(i);
            end
        end
    end

    assign limit_hit  = HoldEn && (hold_q == HoldLast);
    assign exit_grant = release_grant || !req[idx_q] || limit_hit;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        idx_d     = idx_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;

        unique case (state_q)
            StIdle, StGap: begin
                if (win_found) begin
                    state_d = StGrant;
                    idx_d   = win_idx;
                    grant_d = 4'b0001 << win_idx;
                    hold_d  = 8'd0;
                end else begin
                    state_d = StIdle;
                    grant_d = 4'b0000;
                end
            end

            StGrant: begin
                if (exit_grant) begin
                    state_d   = StGap;
                    grant_d   = 4'b0000;
                    ptr_d     = idx_q + 2'd1;
                    // Only a pure limit expiry is reported; release or a
                    // dropped request take precedence.
                    timeout_d = !release_grant && req[idx_q];
                end else if (hold_q != 8'hFF) begin
                    hold_d = hold_q + 8'd1;
                end
            end

            default: begin
                state_d = StIdle;
                grant_d = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!Reset_L) begin
            state_q   <= StIdle;
            ptr_q     <= 2'd0;
            grant_q   <= 4'b0000;
            idx_q     <= 2'd0;
            hold_q    <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            idx_q     <= idx_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant     = grant_q;
    assign grant_idx = idx_q;
    assign busy      = (state_q == StGrant);
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// tb_rr_arbiter4: directed vector table plus hand-written multi-cycle
// sequences for rr_arbiter4 (MAX_HOLD = 4, and MAX_HOLD = 0 alongside).

module tb_rr_arbiter4;

    logic       clk;
    logic       rst_l;
    logic [3:0] req;
    logic       rel;

    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic       busy;
    logic       timeout;

    logic [3:0] grant_nl;
    logic [1:0] grant_idx_nl;
    logic       busy_nl;
    logic       timeout_nl;

    int tests_run = 0;
    int tests_failed = 0;

    rr_arbiter4 #(.MAX_HOLD(4)) dut (
        .CLK          (clk),
        .Reset_L      (rst_l),
        .req          (req),
        .release_grant(rel),
        .grant        (grant),
        .grant_idx    (grant_idx),
        .busy         (busy),
        .timeout      (timeout)
    );

    rr_arbiter4 #(.MAX_HOLD(0)) dut_nolimit (
        .CLK          (clk),
        .Reset_L      (rst_l),
        .req          (req),
        .release_grant(rel),
        .grant        (grant_nl),
        .grant_idx    (grant_idx_nl),
        .busy         (busy_nl),
        .timeout      (timeout_nl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst_l;
        logic [3:0] req;
        logic       rel;
        logic [3:0] grant;
        logic [1:0] idx;
        logic       busy;
        logic       to;
    } vec_t;

    localparam int NumVec = 41;
    vec_t vecs [NumVec];

    function automatic vec_t mk(input logic r, input logic [3:0] q, input logic l,
                                input logic [3:0] g, input logic [1:0] i,
                                input logic b, input logic t);
        vec_t v;
        v.rst_l = r; v.req = q; v.rel = l;
        v.grant = g; v.idx = i; v.busy = b; v.to = t;
        return v;
    endfunction

    // Apply inputs, clock once, sample 1 time unit after the edge.
    task automatic step(input logic r, input logic [3:0] q, input logic l);
        rst_l = r;
        req   = q;
        rel   = l;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] g, input logic [1:0] i,
                         input logic b, input logic t);
        tests_run++;
        if (grant !== g || grant_idx !== i || busy !== b || timeout !== t) begin
            tests_failed++;
            $display("FAIL %s: got grant=%b idx=%0d busy=%b timeout=%b, want grant=%b idx=%0d busy=%b timeout=%b",
                     name, grant, grant_idx, busy, timeout, g, i, b, t);
        end
    endtask

    task automatic check_nl(input string name, input logic [3:0] g, input logic t);
        tests_run++;
        if (grant_nl !== g || timeout_nl !== t || busy_nl !== (g != 4'b0000)) begin
            tests_failed++;
            $display("FAIL %s: got grant=%b busy=%b timeout=%b, want grant=%b timeout=%b",
                     name, grant_nl, busy_nl, timeout_nl, g, t);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //                 rst  req      rel   grant    idx busy to
        // reset values with all requesting
        vecs[0]  = mk(1'b0, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
        vecs[1]  = mk(1'b0, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
        // single request, release, re-grant after GAP
        vecs[2]  = mk(1'b1, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
        vecs[3]  = mk(1'b1, 4'b0100, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0);
        vecs[4]  = mk(1'b1, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
        vecs[5]  = mk(1'b1, 4'b0100, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0);
        vecs[6]  = mk(1'b1, 4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0);
        vecs[7]  = mk(1'b1, 4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0);
        // rotation 0,1,2,3,0 with releases
        vecs[8]  = mk(1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
        vecs[9]  = mk(1'b1, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
        vecs[10] = mk(1'b1, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
        vecs[11] = mk(1'b1, 4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
        vecs[12] = mk(1'b1, 4'b1111, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0);
        vecs[13] = mk(1'b1, 4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
        vecs[14] = mk(1'b1, 4'b1111, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0);
        vecs[15] = mk(1'b1, 4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0);
        vecs[16] = mk(1'b1, 4'b1111, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0);
        vecs[17] = mk(1'b1, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
        vecs[18] = mk(1'b1, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
        // hold limit: 4 grant cycles, timeout pulse, re-grant
        vecs[19] = mk(1'b1, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
        vecs[20] = mk(1'b1, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
        vecs[21] = mk(1'b1, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
        vecs[22] = mk(1'b1, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
        vecs[23] = mk(1'b1, 4'b0010, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b1);
        vecs[24] = mk(1'b1, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
        // release on the limit cycle counts as release: no timeout
        vecs[25] = mk(1'b1, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
        vecs[26] = mk(1'b1, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
        vecs[27] = mk(1'b1, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
        vecs[28] = mk(1'b1, 4'b0010, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0);
        vecs[29] = mk(1'b1, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
        // request drop by owner 3, pointer wraps to 0
        vecs[30] = mk(1'b1, 4'b1001, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0);
        vecs[31] = mk(1'b1, 4'b1001, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0);
        vecs[32] = mk(1'b1, 4'b0001, 1'b0, 4'b0000, 2'd3, 1'b0, 1'b0);
        vecs[33] = mk(1'b1, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
        // reset mid-grant of owner 3, then ptr = 0 picks master 1
        vecs[34] = mk(1'b1, 4'b1000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
        vecs[35] = mk(1'b1, 4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0);
        vecs[36] = mk(1'b0, 4'b1000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
        vecs[37] = mk(1'b1, 4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
        // release is ignored in GAP and IDLE
        vecs[38] = mk(1'b1, 4'b1010, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0);
        vecs[39] = mk(1'b1, 4'b0000, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0);
        vecs[40] = mk(1'b1, 4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0);

        rst_l = 1'b0;
        req   = 4'b0000;
        rel   = 1'b0;

        for (int n = 0; n < NumVec; n++) begin
            step(vecs[n].rst_l, vecs[n].req, vecs[n].rel);
            check($sformatf("vec%0d", n), vecs[n].grant, vecs[n].idx, vecs[n].busy, vecs[n].to);
        end

        // Fairness under continuous load: each owner holds for 4 cycles,
        // then a GAP with a timeout pulse; the unlimited instance never lets go.
        step(1'b0, 4'b1111, 1'b0);
        check("fair_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            logic [3:0] exp_g;
            exp_g = 4'b0001 << (k % 4);
            for (int c = 0; c < 4; c++) begin
                step(1'b1, 4'b1111, 1'b0);
                check($sformatf("fair_own%0d_c%0d", k, c), exp_g, 2'(k % 4), 1'b1, 1'b0);
                check_nl($sformatf("nolimit_own%0d_c%0d", k, c), 4'b0001, 1'b0);
            end
            step(1'b1, 4'b1111, 1'b0);
            check($sformatf("fair_gap%0d", k), 4'b0000, 2'(k % 4), 1'b0, 1'b1);
            check_nl($sformatf("nolimit_gap%0d", k), 4'b0001, 1'b0);
        end

        // Reset on the cycle the limit would expire: no timeout pulse.
        step(1'b0, 4'b0000, 1'b0);
        for (int c = 0; c < 4; c++) begin
            step(1'b1, 4'b0001, 1'b0);
            check($sformatf("rst_lim_c%0d", c), 4'b0001, 2'd0, 1'b1, 1'b0);
        end
        step(1'b0, 4'b0001, 1'b0);
        check("rst_at_limit", 4'b0000, 2'd0, 1'b0, 1'b0);
        step(1'b1, 4'b0000, 1'b0);
        check("rst_at_limit_after", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Owner drop coinciding with the limit: drop wins, no timeout.
        for (int c = 0; c < 4; c++) begin
            step(1'b1, 4'b0100, 1'b0);
            if (c == 0) check("drop_lim_first", 4'b0100, 2'd2, 1'b1, 1'b0);
        end
        step(1'b1, 4'b0000, 1'b0);
        check("drop_at_limit", 4'b0000, 2'd2, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
